// File: rtl/mcs6530_pkg.sv
// Shared types and constants for the MCS6530 host bridge: target select codes,
// controller states, idle bus levels and the error read value.
package mcs6530_pkg;

    typedef enum logic [1:0] {
        SEL_ROM = 2'd0,
        SEL_RAM = 2'd1,
        SEL_IOT = 2'd2,
        SEL_BAD = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StAccess  = 2'd1,
        StCapture = 2'd2,
        StResp    = 2'd3
    } state_e;

    localparam logic       IDLE_CS1   = 1'b1;
    localparam logic       IDLE_CS2   = 1'b1;
    localparam logic       IDLE_RS_N  = 1'b1;
    localparam logic       IDLE_WE_N  = 1'b1;
    localparam logic [9:0] IDLE_A     = 10'h000;
    localparam logic [7:0] IDLE_WDATA = 8'h00;
    localparam logic [7:0] ERR_RDATA  = 8'hFF;

endpackage

// File: rtl/mcs6530_irq_edge.sv
// Registered falling-edge detector on the device interrupt line with a
// set/ack pending latch; a new edge wins over a simultaneous acknowledge.
module mcs6530_irq_edge (
    input  logic phi2,
    input  logic rst,
    input  logic irq_n,
    input  logic ack,
    output logic pending
);

    logic r_irq_n_hist;
    logic r_pending;
    logic w_fall;

    assign w_fall  = r_irq_n_hist & ~irq_n;
    assign pending = r_pending;

    always_ff @(posedge phi2) begin
        if (rst) begin
            r_irq_n_hist <= 1'b1;
            r_pending    <= 1'b0;
        end else begin
            r_irq_n_hist <= irq_n;
            if (w_fall) begin
                r_pending <= 1'b1;
            end else if (ack) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/mcs6530_host.sv
// Request/response bridge to an MCS6530 ROM/RAM/IO-timer device. Optional
// interrupt edge latch enabled by defining MCS6530_HOST_IRQ_EN.
module mcs6530_host
    import mcs6530_pkg::*;
#(
    parameter int unsigned SEL_W = 2
) (
    input  logic             phi2,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_sel,
    input  logic             req_we,
    input  logic [9:0]       req_addr,
    input  logic [7:0]       req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [7:0]       resp_rdata,
    output logic             resp_err,
    output logic [9:0]       bus_a,
    output logic             bus_we_n,
    output logic [7:0]       bus_wdata,
    input  logic [7:0]       bus_rdata,
    input  logic             bus_oe,
    output logic             bus_cs1,
    output logic             bus_cs2,
    output logic             bus_rs_n,
    input  logic             bus_irq_n,
    output logic             irq_pending,
    input  logic             irq_ack
);

    state_e     r_state, w_state_d;
    sel_e       r_sel, w_sel_d;
    logic       r_we, w_we_d;
    logic [9:0] r_bus_a, w_bus_a_d;
    logic [7:0] r_bus_wdata, w_bus_wdata_d;
    logic       r_bus_we_n, w_bus_we_n_d;
    logic       r_cs1, w_cs1_d;
    logic       r_cs2, w_cs2_d;
    logic       r_rs_n, w_rs_n_d;
    logic [7:0] r_rdata, w_rdata_d;
    logic       r_err, w_err_d;
    sel_e       w_req_sel;

    // Any select code beyond IOT is treated as invalid.
    assign w_req_sel = (req_sel > SEL_W'(2)) ? SEL_BAD : sel_e'(req_sel[1:0]);

    always_comb begin
        w_state_d     = r_state;
        w_sel_d       = r_sel;
        w_we_d        = r_we;
        w_bus_a_d     = r_bus_a;
        w_bus_wdata_d = r_bus_wdata;
        w_bus_we_n_d  = r_bus_we_n;
        w_cs1_d       = r_cs1;
        w_cs2_d       = r_cs2;
        w_rs_n_d      = r_rs_n;
        w_rdata_d     = r_rdata;
        w_err_d       = r_err;

        unique case (r_state)
            StIdle: begin
                if (req_valid) begin
                    if (w_req_sel == SEL_BAD) begin
                        w_rdata_d = ERR_RDATA;
                        w_err_d   = 1'b1;
                        w_state_d = StResp;
                    end else begin
                        w_sel_d       = w_req_sel;
                        w_we_d        = req_we;
                        w_bus_a_d     = req_addr;
                        w_bus_wdata_d = req_we ? req_wdata : IDLE_WDATA;
                        // ROM is read-only: a write selects it but never strobes.
                        w_bus_we_n_d  = ~(req_we && (w_req_sel != SEL_ROM));
                        if (w_req_sel == SEL_ROM) begin
                            w_cs1_d  = 1'b1;
                            w_cs2_d  = 1'b0;
                            w_rs_n_d = 1'b0;
                        end else begin
                            w_cs1_d  = 1'b0;
                            w_cs2_d  = 1'b1;
                            w_rs_n_d = 1'b1;
                        end
                        w_state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                w_bus_a_d     = IDLE_A;
                w_bus_wdata_d = IDLE_WDATA;
                w_bus_we_n_d  = IDLE_WE_N;
                w_cs1_d       = IDLE_CS1;
                w_cs2_d       = IDLE_CS2;
                w_rs_n_d      = IDLE_RS_N;
                if (r_we) begin
                    w_rdata_d = 8'h00;
                    w_err_d   = 1'b0;
                    w_state_d = StResp;
                end else begin
                    w_state_d = StCapture;
                end
            end
            StCapture: begin
                if ((r_sel == SEL_IOT) && !bus_oe) begin
                    w_rdata_d = ERR_RDATA;
                    w_err_d   = 1'b1;
                end else begin
                    w_rdata_d = bus_rdata;
                    w_err_d   = 1'b0;
                end
                w_state_d = StResp;
            end
            StResp: begin
                if (resp_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge phi2) begin
        if (rst) begin
            r_state     <= StIdle;
            r_sel       <= SEL_ROM;
            r_we        <= 1'b0;
            r_bus_a     <= IDLE_A;
            r_bus_wdata <= IDLE_WDATA;
            r_bus_we_n  <= IDLE_WE_N;
            r_cs1       <= IDLE_CS1;
            r_cs2       <= IDLE_CS2;
            r_rs_n      <= IDLE_RS_N;
            r_rdata     <= 8'h00;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_sel       <= w_sel_d;
            r_we        <= w_we_d;
            r_bus_a     <= w_bus_a_d;
            r_bus_wdata <= w_bus_wdata_d;
            r_bus_we_n  <= w_bus_we_n_d;
            r_cs1       <= w_cs1_d;
            r_cs2       <= w_cs2_d;
            r_rs_n      <= w_rs_n_d;
            r_rdata     <= w_rdata_d;
            r_err       <= w_err_d;
        end
    end

    assign req_ready  = (r_state == StIdle);
    assign resp_valid = (r_state == StResp);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign bus_a      = r_bus_a;
    assign bus_wdata  = r_bus_wdata;
    assign bus_we_n   = r_bus_we_n;
    assign bus_cs1    = r_cs1;
    assign bus_cs2    = r_cs2;
    assign bus_rs_n   = r_rs_n;

`ifdef MCS6530_HOST_IRQ_EN
    mcs6530_irq_edge u_irq_edge (
        .phi2    (phi2),
        .rst     (rst),
        .irq_n   (bus_irq_n),
        .ack     (irq_ack),
        .pending (irq_pending)
    );
`else
    logic w_unused_irq;
    assign w_unused_irq = bus_irq_n ^ irq_ack;
    assign irq_pending  = 1'b0;
`endif

endmodule

// File: tb/tb_mcs6530_host.sv
// Self-checking bench for mcs6530_host: vector table with a response
// scoreboard, plus reset-during-access and interrupt sequences.
module tb_mcs6530_host;

    logic       phi2 = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_we;
    logic [1:0] req_sel;
    logic [9:0] req_addr;
    logic [7:0] req_wdata;
    logic       resp_valid, resp_ready, resp_err;
    logic [7:0] resp_rdata;
    logic [9:0] bus_a;
    logic       bus_we_n, bus_oe, bus_cs1, bus_cs2, bus_rs_n, bus_irq_n;
    logic [7:0] bus_wdata, bus_rdata;
    logic       irq_pending, irq_ack;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] sel;
        logic       we;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] dev_rdata;
        logic       dev_oe;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_lat;
        int         hold;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    mcs6530_host #(.SEL_W(2)) dut (
        .phi2        (phi2),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_sel     (req_sel),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .bus_a       (bus_a),
        .bus_we_n    (bus_we_n),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_oe      (bus_oe),
        .bus_cs1     (bus_cs1),
        .bus_cs2     (bus_cs2),
        .bus_rs_n    (bus_rs_n),
        .bus_irq_n   (bus_irq_n),
        .irq_pending (irq_pending),
        .irq_ack     (irq_ack)
    );

    always #5 phi2 = ~phi2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge phi2);
        #1;
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, " cs1"}, 32'(bus_cs1), 32'd1);
        chk({tag, " cs2"}, 32'(bus_cs2), 32'd1);
        chk({tag, " rs_n"}, 32'(bus_rs_n), 32'd1);
        chk({tag, " we_n"}, 32'(bus_we_n), 32'd1);
        chk({tag, " a"}, 32'(bus_a), 32'd0);
        chk({tag, " wdata"}, 32'(bus_wdata), 32'd0);
    endtask

    task automatic run_txn(input int idx);
        vec_t v;
        exp_t e;
        int   k;
        logic [7:0] held_rdata;
        logic       held_err;
        v = vecs[idx];
        chk($sformatf("v%0d req_ready idle", idx), 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_sel   = v.sel;
        req_we    = v.we;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat});
        step();
        // Garbage request held while busy must be ignored.
        req_sel   = 2'd3;
        req_we    = ~v.we;
        req_addr  = 10'h2C3;
        req_wdata = 8'h69;
        k = 1;
        while (!resp_valid && k < 8) begin
            if (k == 1 && v.sel != 2'd3) begin
                chk($sformatf("v%0d access cs1", idx), 32'(bus_cs1), (v.sel == 2'd0) ? 32'd1 : 32'd0);
                chk($sformatf("v%0d access cs2", idx), 32'(bus_cs2), (v.sel == 2'd0) ? 32'd0 : 32'd1);
                chk($sformatf("v%0d access rs_n", idx), 32'(bus_rs_n), (v.sel == 2'd0) ? 32'd0 : 32'd1);
                chk($sformatf("v%0d access we_n", idx), 32'(bus_we_n),
                    (v.we && v.sel != 2'd0) ? 32'd0 : 32'd1);
                chk($sformatf("v%0d access a", idx), 32'(bus_a), 32'(v.addr));
                if (v.we) chk($sformatf("v%0d access wdata", idx), 32'(bus_wdata), 32'(v.wdata));
            end
            if (k == 2) begin
                chk_bus_idle($sformatf("v%0d post-access", idx));
                if (!v.we) begin
                    bus_rdata = v.dev_rdata;
                    bus_oe    = v.dev_oe;
                end
            end
            step();
            bus_oe    = 1'b0;
            bus_rdata = 8'hE7;
            k++;
        end
        if (!resp_valid) begin
            chk($sformatf("v%0d resp timeout", idx), 32'(resp_valid), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (sb.size() == 0) begin
            chk($sformatf("v%0d scoreboard empty", idx), 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d latency", idx), 32'(k), 32'(e.lat));
        chk($sformatf("v%0d rdata", idx), 32'(resp_rdata), 32'(e.rdata));
        chk($sformatf("v%0d err", idx), 32'(resp_err), 32'(e.err));
        if (v.sel == 2'd3) chk_bus_idle($sformatf("v%0d bad sel bus", idx));
        held_rdata = resp_rdata;
        held_err   = resp_err;
        for (int h = 0; h < v.hold; h++) begin
            step();
            chk($sformatf("v%0d hold%0d valid", idx, h), 32'(resp_valid), 32'd1);
            chk($sformatf("v%0d hold%0d rdata", idx, h), 32'(resp_rdata), 32'(held_rdata));
            chk($sformatf("v%0d hold%0d err", idx, h), 32'(resp_err), 32'(held_err));
            chk($sformatf("v%0d hold%0d req_ready", idx, h), 32'(req_ready), 32'd0);
            if (v.sel == 2'd3) begin
                chk($sformatf("v%0d hold%0d cs1", idx, h), 32'(bus_cs1), 32'd1);
                chk($sformatf("v%0d hold%0d cs2", idx, h), 32'(bus_cs2), 32'd1);
                chk($sformatf("v%0d hold%0d rs_n", idx, h), 32'(bus_rs_n), 32'd1);
            end
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk($sformatf("v%0d post resp_valid", idx), 32'(resp_valid), 32'd0);
        chk($sformatf("v%0d post req_ready", idx), 32'(req_ready), 32'd1);
    endtask

    initial begin
        //          sel    we    addr     wdata  dev    oe    rdata  err  lat hold
        vecs[0] = '{2'd1, 1'b1, 10'h385, 8'hA5, 8'h00, 1'b0, 8'h00, 1'b0, 2, 0};
        vecs[1] = '{2'd2, 1'b0, 10'h000, 8'h00, 8'h3C, 1'b1, 8'h3C, 1'b0, 3, 1};
        vecs[2] = '{2'd2, 1'b0, 10'h011, 8'h00, 8'h77, 1'b0, 8'hFF, 1'b1, 3, 0};
        vecs[3] = '{2'd0, 1'b0, 10'h3FF, 8'h00, 8'h4C, 1'b0, 8'h4C, 1'b0, 3, 0};
        vecs[4] = '{2'd3, 1'b0, 10'h155, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1, 5};
        vecs[5] = '{2'd0, 1'b1, 10'h123, 8'h5A, 8'h00, 1'b0, 8'h00, 1'b0, 2, 0};
        vecs[6] = '{2'd2, 1'b1, 10'h2AA, 8'h11, 8'h00, 1'b0, 8'h00, 1'b0, 2, 2};
        vecs[7] = '{2'd1, 1'b0, 10'h0F0, 8'h00, 8'h96, 1'b1, 8'h96, 1'b0, 3, 0};

        rst = 1'b1;
        req_valid = 1'b0; req_sel = 2'd0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; bus_rdata = 8'hE7; bus_oe = 1'b0; bus_irq_n = 1'b1; irq_ack = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_bus_idle("reset");
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rdata", 32'(resp_rdata), 32'd0);
        chk("reset err", 32'(resp_err), 32'd0);
        chk("reset irq_pending", 32'(irq_pending), 32'd0);

        for (int i = 0; i < 8; i++) run_txn(i);

        // Reset landing in the ACCESS cycle of a RAM write.
        req_valid = 1'b1; req_sel = 2'd1; req_we = 1'b1; req_addr = 10'h0AB; req_wdata = 8'hC3;
        step();
        req_valid = 1'b0;
        chk("rst-mid access cs1", 32'(bus_cs1), 32'd0);
        chk("rst-mid access we_n", 32'(bus_we_n), 32'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_bus_idle("rst-mid");
        chk("rst-mid resp_valid", 32'(resp_valid), 32'd0);
        chk("rst-mid req_ready", 32'(req_ready), 32'd1);
        step();
        chk("rst-mid no late resp", 32'(resp_valid), 32'd0);

        run_txn(7);

`ifdef MCS6530_HOST_IRQ_EN
        chk("irq quiet", 32'(irq_pending), 32'd0);
        bus_irq_n = 1'b0;
        step();
        chk("irq fall sets", 32'(irq_pending), 32'd1);
        step();
        chk("irq held low", 32'(irq_pending), 32'd1);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("irq ack clears", 32'(irq_pending), 32'd0);
        step();
        chk("irq low no re-set", 32'(irq_pending), 32'd0);
        bus_irq_n = 1'b1;
        step();
        bus_irq_n = 1'b0;
        irq_ack   = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("irq set beats ack", 32'(irq_pending), 32'd1);
`else
        for (int i = 0; i < 6; i++) begin
            bus_irq_n = i[0];
            irq_ack   = i[1];
            step();
            chk($sformatf("irq disabled %0d", i), 32'(irq_pending), 32'd0);
        end
        irq_ack = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcs6530_host.md
MCS6530_HOST -- requirements
Module: mcs6530_host

Interface
REQ-001 Parameter SEL_W, default 2, width of the request target-select field.
REQ-002 phi2  input  1  Sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  Reset: synchronous, active-high, sampled on rising phi2.
REQ-004 req_valid  input  1  Transaction request present.
REQ-005 req_ready  output  1  High only in IDLE; the request is accepted on valid&ready.
REQ-006 req_sel  input  SEL_W  Target select: 0=ROM, 1=RAM, 2=IOT, 3=invalid.
REQ-007 req_we  input  1  1=write, 0=read.
REQ-008 req_addr  input  10  Device address.
REQ-009 req_wdata  input  8  Write data.
REQ-010 resp_valid / resp_ready  output / input  1 / 1  Response handshake.
REQ-011 resp_rdata  output  8  Read data (0x00 for writes).
REQ-012 resp_err  output  1  Invalid select, or an IOT read without the device's data-valid strobe.
REQ-013 bus_a  output  10  Address to device.
REQ-014 bus_we_n  output  1  Active-low write strobe.
REQ-015 bus_wdata  output  8  Data to device.
REQ-016 bus_rdata  input  8  Data from device.
REQ-017 bus_oe  input  1  Device data-valid strobe (one-cycle pulse).
REQ-018 bus_cs1 / bus_cs2 / bus_rs_n  output  1 each  Device selects.
REQ-019 bus_irq_n  input  1  Active-low device interrupt.
REQ-020 irq_pending  output  1  Latched interrupt event.
REQ-021 irq_ack  input  1  One-cycle clear of irq_pending.

Function
REQ-022 FSM states: IDLE, ACCESS, CAPTURE, RESP; all bus outputs are registered.
REQ-023 Idle bus levels: cs1=1, cs2=1, rs_n=1, we_n=1, a=0, wdata=0.
REQ-024 IDLE, valid request with sel 0-2: drive the bus at that edge and go to ACCESS; ROM uses rs_n=0, cs2=0, cs1=1; RAM/IOT use cs1=0, rs_n=1, cs2=1.
REQ-025 ROM write requests drive the ROM selects with we_n=1 (no write) and complete as a normal write with err=0.
REQ-026 ACCESS lasts exactly one cycle; the bus returns to idle levels at its end.
REQ-027 Writes go ACCESS->RESP with rdata=0x00 and err=0.
REQ-028 Reads go ACCESS->CAPTURE; in CAPTURE, bus_rdata is registered into resp_rdata, then go to RESP.
REQ-029 IOT read in CAPTURE with bus_oe=0: rdata=0xFF, err=1; ROM/RAM reads ignore bus_oe.
REQ-030 sel=3: no bus activity; IDLE->RESP next edge with rdata=0xFF, err=1.
REQ-031 RESP: resp_valid=1 with stable rdata/err until resp_ready; on the handshake go to IDLE. The next request is accepted no earlier than the following edge.
REQ-032 Latency from accept to resp_valid: write 2 cycles, read 3 cycles, invalid 1 cycle.
REQ-033 req_* inputs are ignored outside IDLE.

Reset
REQ-034 rst in any state, including mid-ACCESS, forces: IDLE, bus idle levels, resp_valid=0, rdata=0, err=0, irq_pending=0, and the irq history register to 1.

Configuration
REQ-035 Macro MCS6530_HOST_IRQ_EN defined: bus_irq_n is registered each cycle.
REQ-036 With the macro defined, irq_pending is set when the registered value is 1 and bus_irq_n is 0 (falling edge).
REQ-037 With the macro defined, irq_ack clears irq_pending; if set and ack occur in the same cycle, set wins.
REQ-038 Macro undefined: irq_pending is constant 0, bus_irq_n is unused, and no irq flops are present.

Structure
REQ-039 Package mcs6530_pkg holds: the sel enum (SEL_ROM, SEL_RAM, SEL_IOT, SEL_BAD), the FSM state enum, idle bus-level constants, and the error read value 0xFF.
REQ-040 One sub-module, mcs6530_irq_edge (registered falling-edge detector with set/ack latch), instantiated only under MCS6530_HOST_IRQ_EN.

Verification
REQ-041 RAM write sel=1, addr=0x385, wdata=0xA5: one ACCESS cycle with cs1=0, we_n=0, a=0x385, wdata=0xA5; response follows 2 cycles after accept with err=0.
REQ-042 IOT read sel=2, addr=0x000; device returns 0x3C with bus_oe=1 in CAPTURE: rdata=0x3C, err=0, 3-cycle latency.
REQ-043 IOT read with bus_oe held 0: rdata=0xFF, err=1. Then ROM read addr=0x3FF with device data 0x4C and oe=0: rdata=0x4C, err=0, rs_n=0, cs2=0 during ACCESS.
REQ-044 sel=3 request: no select asserted at any cycle; response next cycle with rdata=0xFF, err=1. Hold resp_ready=0 for 5 cycles: response stays stable and req_ready=0.
REQ-045 Assert rst during ACCESS of a write: the next edge shows idle bus levels, resp_valid=0, req_ready=1.
REQ-046 With the IRQ macro: bus_irq_n 1->0 sets irq_pending; irq_ack in the same cycle as a new falling edge leaves irq_pending=1. Without the macro: irq_pending stays 0 throughout.
